// File: rtl/csel_pkg.sv
// Shared constants and helpers for the pipelined carry-select adder.
package csel_pkg;

    localparam int CSEL_WIDTH = 32;
    localparam int CSEL_BLK   = 8;

    function automatic int csel_stages(input int width, input int blk);
        return width / blk;
    endfunction

    function automatic bit csel_cfg_ok(input int width, input int blk);
        return (blk >= 1) && (blk <= width) && ((width % blk) == 0);
    endfunction

endpackage

// File: rtl/csel_slice.sv
// Combinational BLK-bit carry-select slice: both carry-in cases computed, sel picks one.
module csel_slice #(
    parameter int BLK = 8
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           sel,
    output logic [BLK-1:0] s,
    output logic           co
);

    logic [BLK-1:0] s0;
    logic [BLK-1:0] s1;
    logic           co0;
    logic           co1;

    always_comb begin
        logic c0;
        logic c1;
        c0 = 1'b0;
        c1 = 1'b1;
        s0 = '0;
        s1 = '0;
        for (int i = 0; i < BLK; i++) begin
            s0[i] = a[i] ^ b[i] ^ c0;
            s1[i] = a[i] ^ b[i] ^ c1;
            c0    = (a[i] & b[i]) | (c0 & (a[i] ^ b[i]));
            c1    = (a[i] & b[i]) | (c1 & (a[i] ^ b[i]));
        end
        co0 = c0;
        co1 = c1;
    end

    assign s  = sel ? s1 : s0;
    assign co = sel ? co1 : co0;

endmodule

// File: rtl/csel_pipe_adder.sv
// Pipelined carry-select adder, one BLK-bit slice per stage, valid/ready on both sides.
// Optional signed-overflow output enabled by defining CSEL_PIPE_OVF_EN.
module csel_pipe_adder
    import csel_pkg::*;
#(
    parameter int WIDTH = CSEL_WIDTH,
    parameter int BLK   = CSEL_BLK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CSEL_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int STAGES = csel_stages(WIDTH, BLK);

    if (!csel_cfg_ok(WIDTH, BLK)) begin : g_bad_cfg
        $error("csel_pipe_adder: WIDTH must be a non-zero multiple of BLK");
    end

    logic [STAGES-1:0] v_reg;
    logic              c_reg   [STAGES];
    logic [WIDTH-1:0]  sum_reg [STAGES];
    logic [WIDTH-1:0]  opa_reg [STAGES];
    logic [WIDTH-1:0]  opb_reg [STAGES];

    logic [STAGES:0]   rdy;
    logic              nxt_v   [STAGES];
    logic [WIDTH-1:0]  nxt_sum [STAGES];
    logic [WIDTH-1:0]  nxt_opa [STAGES];
    logic [WIDTH-1:0]  nxt_opb [STAGES];

    logic [BLK-1:0]    sl_a    [STAGES];
    logic [BLK-1:0]    sl_b    [STAGES];
    logic [BLK-1:0]    sl_s    [STAGES];
    logic              sl_sel  [STAGES];
    logic              sl_co   [STAGES];

    // rdy[k] means stage k may load this cycle; an empty stage anywhere
    // downstream lets everything in front of it advance (bubbles collapse).
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = !v_reg[k] || rdy[k+1];
        end
    end

    genvar gi;
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_first
            assign sl_a[gi]    = a[BLK-1:0];
            assign sl_b[gi]    = b[BLK-1:0];
            assign sl_sel[gi]  = cin;
            assign nxt_v[gi]   = in_valid;
            assign nxt_sum[gi] = WIDTH'(sl_s[gi]);
            assign nxt_opa[gi] = a;
            assign nxt_opb[gi] = b;
        end else begin : g_rest
            assign sl_a[gi]    = opa_reg[gi-1][gi*BLK +: BLK];
            assign sl_b[gi]    = opb_reg[gi-1][gi*BLK +: BLK];
            assign sl_sel[gi]  = c_reg[gi-1];
            assign nxt_v[gi]   = v_reg[gi-1];
            // Upper bits of the accumulated sum are always zero, so OR inserts the slice.
            assign nxt_sum[gi] = sum_reg[gi-1] | (WIDTH'(sl_s[gi]) << (gi * BLK));
            assign nxt_opa[gi] = opa_reg[gi-1];
            assign nxt_opb[gi] = opb_reg[gi-1];
        end

        csel_slice #(.BLK(BLK)) u_slice (
            .a   (sl_a[gi]),
            .b   (sl_b[gi]),
            .sel (sl_sel[gi]),
            .s   (sl_s[gi]),
            .co  (sl_co[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_reg <= '0;
            for (int k = 0; k < STAGES; k++) begin
                c_reg[k]   <= 1'b0;
                sum_reg[k] <= '0;
                opa_reg[k] <= '0;
                opb_reg[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    v_reg[k]   <= nxt_v[k];
                    c_reg[k]   <= sl_co[k];
                    sum_reg[k] <= nxt_sum[k];
                    opa_reg[k] <= nxt_opa[k];
                    opb_reg[k] <= nxt_opb[k];
                end
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_reg[STAGES-1];
    assign sum       = sum_reg[STAGES-1];
    assign cout      = c_reg[STAGES-1];

`ifdef CSEL_PIPE_OVF_EN
    // Original operand MSBs ride along in the operand registers to the last stage.
    assign ovf = v_reg[STAGES-1]
               && (opa_reg[STAGES-1][WIDTH-1] == opb_reg[STAGES-1][WIDTH-1])
               && (sum_reg[STAGES-1][WIDTH-1] != opa_reg[STAGES-1][WIDTH-1]);
`endif

endmodule

// File: tb/tb_csel_pipe_adder.sv
// Self-checking bench for csel_pipe_adder: directed phases with random operands vs. a queue model.
module tb_csel_pipe_adder;

`ifdef CSEL_PIPE_OVF_EN
    localparam int W = 16;
    localparam int B = 4;
`else
    localparam int W = 32;
    localparam int B = 8;
`endif
    localparam int S = W / B;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef CSEL_PIPE_OVF_EN
    logic         ovf;
    logic         ovf_q[$];
`endif

    csel_pipe_adder #(.WIDTH(W), .BLK(B)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CSEL_PIPE_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    int           n_assert = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    bit           lat_chk  = 1'b0;
    bit           hold_pending = 1'b0;
    logic [W:0]   hold_val;
    logic [W:0]   exp_q[$];
    int           acc_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // One clock: drive inputs, check outputs mid-cycle against the model, then step the clock.
    task automatic step(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ic, input logic ordy);
        logic [W:0] res;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        cin       = ic;
        out_ready = ordy;
        #2;
        chk("in_ready", 64'(in_ready), 64'((exp_q.size() < S) || ordy));
        if (hold_pending) begin
            chk("hold", 64'({out_valid, cout, sum}), 64'({1'b1, hold_val}));
        end
        hold_pending = 1'b0;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 64'(out_valid), 64'(0));
            end else begin
                chk("result", 64'({cout, sum}), 64'(exp_q[0]));
`ifdef CSEL_PIPE_OVF_EN
                chk("ovf", 64'(ovf), 64'(ovf_q[0]));
`endif
                if (lat_chk) chk("latency", 64'(cyc - acc_q[0]), 64'(S));
                if (ordy) begin
                    void'(exp_q.pop_front());
                    void'(acc_q.pop_front());
`ifdef CSEL_PIPE_OVF_EN
                    void'(ovf_q.pop_front());
`endif
                end else begin
                    hold_pending = 1'b1;
                    hold_val     = {cout, sum};
                end
            end
        end
        if (iv && in_ready) begin
            res = {1'b0, ia} + {1'b0, ib} + (W+1)'(ic);
            exp_q.push_back(res);
            acc_q.push_back(cyc);
`ifdef CSEL_PIPE_OVF_EN
            ovf_q.push_back((ia[W-1] == ib[W-1]) && (res[W-1] != ia[W-1]));
`endif
            $display("cyc %0d accept a=0x%0h b=0x%0h cin=%0d -> expect 0x%0h", cyc, ia, ib, ic, res);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        exp_q.delete();
        acc_q.delete();
`ifdef CSEL_PIPE_OVF_EN
        ovf_q.delete();
`endif
        hold_pending = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_sum", 64'(sum), 64'(0));
        chk("rst_cout", 64'(cout), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
`ifdef CSEL_PIPE_OVF_EN
        chk("rst_ovf", 64'(ovf), 64'(0));
`endif
    endtask

    function automatic logic [W-1:0] rnd();
        return W'({$urandom(), $urandom()});
    endfunction

    initial begin
        logic [W-1:0] ones;
        ones      = '1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single op with full carry ripple through every slice.
        lat_chk = 1'b1;
        step(1'b1, ones, W'(1), 1'b0, 1'b1);
        repeat (S + 2) step(1'b0, '0, '0, 1'b0, 1'b1);

        // Back-to-back stream: one result per cycle, fixed latency.
        for (int i = 0; i < 100; i++) step(1'b1, rnd(), rnd(), 1'($urandom_range(1)), 1'b1);
        repeat (S + 2) step(1'b0, '0, '0, 1'b0, 1'b1);

        // Backpressure: fill, hold for 5+ cycles, then drain.
        lat_chk = 1'b0;
        for (int i = 0; i < S + 5; i++) step(1'b1, rnd(), rnd(), 1'($urandom_range(1)), 1'b0);
        repeat (S + 2) step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("drain_bp", 64'(exp_q.size()), 64'(0));

        // Bubbles: input every third cycle.
        lat_chk = 1'b1;
        for (int i = 0; i < 30; i++) step(1'(i % 3 == 0), rnd(), rnd(), 1'($urandom_range(1)), 1'b1);
        repeat (S + 2) step(1'b0, '0, '0, 1'b0, 1'b1);

        // Random valid and ready.
        lat_chk = 1'b0;
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(1)), rnd(), rnd(), 1'($urandom_range(1)), 1'($urandom_range(3) != 0));
        repeat (3 * S) step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("drain_rand", 64'(exp_q.size()), 64'(0));

`ifdef CSEL_PIPE_OVF_EN
        lat_chk = 1'b1;
        step(1'b1, W'(16'h7FFF), W'(1), 1'b0, 1'b1);
        step(1'b1, W'(16'hFFFF), W'(1), 1'b0, 1'b1);
        repeat (S + 2) step(1'b0, '0, '0, 1'b0, 1'b1);
`endif

        // Reset with three ops in flight: none may ever emerge.
        lat_chk = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, rnd(), rnd(), 1'b0, 1'b1);
        do_reset();
        repeat (S + 4) step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("drain_final", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
